// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the sequential fetch address and keeps one
// request in flight to instruction memory at a time. Returned words are
// buffered with their addresses in a small FIFO that feeds decode. A redirect
// flushes the buffer. If a response is still owed when the redirect arrives,
// the fetch unit drains that response before it issues the next request.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic [31:0] fetch_pc
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t          state, state_nxt;
  logic [31:0]     req_pc;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     pc_q    [DEPTH];
  logic [31:0]     instr_q [DEPTH];
  logic            push, pop, req_fire;

  // The low address bits of a redirect target are dropped by construction.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign mem_req_addr = fetch_pc;
  assign req_fire     = mem_req_valid && mem_req_ready;
  assign instr_valid  = (count != '0);
  // A redirect flushes the FIFO, so a pop in that cycle must not move the pointer.
  assign pop          = instr_valid && instr_ready && !redirect_valid;
  assign instr_out    = instr_q[rd_ptr];
  assign instr_pc     = pc_q[rd_ptr];

  // Next-state, request-valid and push decode.
  always_comb begin
    state_nxt     = state;
    mem_req_valid = 1'b0;
    push          = 1'b0;
    case (state)
      S_REQ: begin
        // Issue a request only when the FIFO has room for the answer.
        mem_req_valid = (count < CW'(DEPTH)) && !redirect_valid && !reset;
        if (mem_req_valid && mem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          state_nxt = S_REQ;
          push      = !redirect_valid;
        end else if (redirect_valid) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_resp_valid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_REQ;
    else       state <= state_nxt;
  end

  // Fetch address: a redirect wins; otherwise advance by 4 once a word lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      if (redirect_valid) fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (push)      fetch_pc <= fetch_pc + 32'd4;
      if (req_fire)       req_pc   <= fetch_pc;
    end
  end

  // Instruction FIFO. The storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr]    <= req_pc;
        instr_q[wr_ptr] <= mem_resp_data;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit. A behavioural memory answers each accepted
// request after a chosen latency. The data it returns is a function of the
// address. The reference model tracks only the address decode should see
// next: reset and redirect set that address, and each delivered word moves
// it on by 4.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, redirect_valid, mem_req_valid, mem_req_ready;
  logic        mem_resp_valid, instr_valid, instr_ready;
  logic [31:0] redirect_pc, mem_req_addr, mem_resp_data, instr_out, instr_pc, fetch_pc;

  logic        w_reset, w_mem_req_valid, w_mem_resp_valid, w_instr_valid;
  logic [31:0] w_mem_req_addr, w_mem_resp_data, w_instr_out, w_instr_pc, w_fetch_pc;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
    .instr_pc(instr_pc), .fetch_pc(fetch_pc));

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_wrap (
    .clk(clk), .reset(w_reset), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .mem_req_valid(w_mem_req_valid), .mem_req_ready(1'b1), .mem_req_addr(w_mem_req_addr),
    .mem_resp_valid(w_mem_resp_valid), .mem_resp_data(w_mem_resp_data),
    .instr_valid(w_instr_valid), .instr_ready(1'b1), .instr_out(w_instr_out),
    .instr_pc(w_instr_pc), .fetch_pc(w_fetch_pc));

  // Single-cycle memory for the wrap-around instance.
  always @(posedge clk) begin
    w_mem_resp_valid <= w_mem_req_valid;
    w_mem_resp_data  <= w_mem_req_addr + 32'h100;
  end

  int          vectors = 0, errors = 0, cyc = 0, n_deliv = 0, wait_cnt = 0, lat = 1;
  bit          rand_mode = 0, prev_pend = 0, hs_last = 0;
  logic [31:0] exp_pc = 0, salt = 0, prev_addr = 0, hs_addr_last = 0, resp_addr = 0;
  int          deliv_cyc[$];
  logic [31:0] wrap_pc[$], wrap_ins[$];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a + 32'h100) ^ salt;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Run one clock: check the settled outputs against the model, step the memory.
  task automatic cycle();
    logic hs;
    logic [31:0] ha;
    #1;
    if (prev_pend && !reset && !redirect_valid) begin
      check("req_valid_hold", 32'(mem_req_valid), 32'd1);
      check("req_addr_hold", mem_req_addr, prev_addr);
    end
    if (reset) exp_pc = 32'h0;
    else if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    else if (instr_valid && instr_ready) begin
      check("instr_pc", instr_pc, exp_pc);
      check("instr_out", instr_out, mem_f(exp_pc));
      exp_pc += 32'd4;
      deliv_cyc.push_back(cyc);
      n_deliv++;
    end
    if (!w_reset && w_instr_valid && wrap_pc.size() < 2) begin
      wrap_pc.push_back(w_instr_pc);
      wrap_ins.push_back(w_instr_out);
    end
    hs = mem_req_valid && mem_req_ready;
    ha = mem_req_addr;
    prev_pend = mem_req_valid && !mem_req_ready;
    prev_addr = mem_req_addr;
    hs_last = hs;
    hs_addr_last = ha;
    @(posedge clk);
    #1;
    cyc++;
    if (mem_resp_valid) mem_resp_valid = 1'b0;
    if (hs) begin
      wait_cnt = rand_mode ? $urandom_range(1, 4) : lat;
      resp_addr = ha;
    end
    if (wait_cnt > 0) begin
      wait_cnt--;
      if (wait_cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data = mem_f(resp_addr);
      end
    end
    if (rand_mode) begin
      mem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    wait_cnt = 0;
    mem_resp_valid = 1'b0;
    #1;
    check("req_valid_in_reset", 32'(mem_req_valid), 32'd0);
    cycle();
    cycle();
    reset = 1'b0;
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_fetch_pc", fetch_pc, 32'h0);
    check("rst_instr_out", instr_out, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, n0;
    bit seen;
    reset = 1'b1; w_reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0; instr_ready = 1'b1;

    // 1: streaming with 1-cycle memory, one instruction every 2 cycles.
    lat = 1;
    do_reset();
    w_reset = 1'b0;
    deliv_cyc.delete();
    start = cyc;
    repeat (10) cycle();
    check("t1_count", 32'(deliv_cyc.size()), 32'd4);
    if (deliv_cyc.size() > 0) check("t1_first_lat", 32'(deliv_cyc[0] - start), 32'd2);
    for (int i = 1; i < 4; i++)
      if (deliv_cyc.size() > i) check("t1_gap", 32'(deliv_cyc[i] - deliv_cyc[i-1]), 32'd2);

    // 2: decode stalled, the FIFO fills and fetch halts.
    do_reset();
    instr_ready = 1'b0;
    repeat (10) cycle();
    check("t2_valid", 32'(instr_valid), 32'd1);
    check("t2_head_pc", instr_pc, 32'h0);
    check("t2_head_instr", instr_out, 32'h100);
    check("t2_req_valid", 32'(mem_req_valid), 32'd0);
    check("t2_fetch_pc", fetch_pc, 32'h8);
    instr_ready = 1'b1;
    deliv_cyc.delete();
    repeat (8) cycle();
    check("t2_drained", 32'(deliv_cyc.size() >= 3), 32'd1);
    if (deliv_cyc.size() >= 2) check("t2_back2back", 32'(deliv_cyc[1] - deliv_cyc[0]), 32'd1);

    // 3: redirect while a 3-cycle response is outstanding.
    do_reset();
    lat = 3;
    instr_ready = 1'b0;
    n0 = 0;
    for (int i = 0; i < 20 && n0 < 2; i++) begin
      cycle();
      if (hs_last) n0++;
    end
    check("t3_two_reqs", 32'(n0), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    cycle();
    redirect_valid = 1'b0;
    check("t3_flushed", 32'(instr_valid), 32'd0);
    instr_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      seen = hs_last;
    end
    check("t3_req_seen", 32'(seen), 32'd1);
    check("t3_req_addr", hs_addr_last, 32'h200);
    check("t3_no_stale", 32'(instr_valid), 32'd0);
    deliv_cyc.delete();
    repeat (8) cycle();
    check("t3_delivered", 32'(deliv_cyc.size() >= 1), 32'd1);

    // 4: memory back-pressure holds the request steady.
    mem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && !mem_req_valid; i++) cycle();
    for (int i = 0; i < 5; i++) begin
      check("t4_valid", 32'(mem_req_valid), 32'd1);
      check("t4_addr", mem_req_addr, 32'h10);
      cycle();
    end
    mem_req_ready = 1'b1;
    cycle();
    check("t4_accept", 32'(hs_last), 32'd1);
    check("t4_accept_addr", hs_addr_last, 32'h10);
    repeat (8) cycle();

    // 6: reset during a wait; the old response lands just after reset.
    do_reset();
    lat = 2;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      seen = hs_last;
    end
    check("t6_req_addr", hs_addr_last, 32'h40);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    check("t6_fresh_req", 32'(hs_last), 32'd1);
    check("t6_fresh_addr", hs_addr_last, 32'h0);
    check("t6_not_pushed", 32'(instr_valid), 32'd0);
    deliv_cyc.delete();
    repeat (6) cycle();
    check("t6_delivered", 32'(deliv_cyc.size() >= 1), 32'd1);

    // Random traffic: latency, both ready signals and redirects all vary.
    do_reset();
    salt = $urandom;
    rand_mode = 1;
    n0 = n_deliv;
    repeat (2000) begin
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      cycle();
    end
    redirect_valid = 1'b0;
    rand_mode = 0;
    check("rand_progress", 32'(n_deliv - n0 > 100), 32'd1);

    // 5: wrap-around instance starting at FFFF_FFFC.
    check("wrap_count", 32'(wrap_pc.size()), 32'd2);
    if (wrap_pc.size() >= 2) begin
      check("wrap_pc0", wrap_pc[0], 32'hFFFF_FFFC);
      check("wrap_pc1", wrap_pc[1], 32'h0000_0000);
      check("wrap_ins0", wrap_ins[0], 32'h0000_00FC);
      check("wrap_ins1", wrap_ins[1], 32'h0000_0100);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
